mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Memory-stage responder for the `mem_op` / `dest_src` control produced by the ID decoder.
- Takes one memory operation per request: opcode, ALU-computed address and store data.
- Runs a req/ack transaction on the data-memory bus, applying byte/half/word lane steering, load sign/zero extension and alignment checks.
- Stalls the pipeline while a transaction is outstanding and returns the load result for writeback.

Parameters:
- WORD_W, `WORD_W (32), data/address width.
- MEM_OP_W, `MEM_OP_W, width of mem_op.
- TIMEOUT, 16, max cycles waiting for ack before error; 1..255.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- op_valid  in  1  request present this cycle.
- op_ready  out  1  unit can accept a request (state IDLE).
- mem_op  in  MEM_OP_W  `MEM_OP_NOP, `MEM_OP_WR_BYTE/HALF/WORD, `MEM_OP_RD_BYTE/BYTEU/HALF/HALFU/WORD (mem_codes.vh carries the RD_* codes).
- addr  in  WORD_W  byte address.
- wdata  in  WORD_W  store data, right-aligned.
- stall  out  1  freeze upstream stages.
- done  out  1  one-cycle pulse: operation complete.
- rdata  out  WORD_W  extended load result, valid with done.
- err  out  1  one-cycle pulse with done: misaligned access or timeout.
- bus_req  out  1  bus request.
- bus_we  out  1  1 = write.
- bus_be  out  4  byte enables.
- bus_addr  out  WORD_W  word-aligned address ({addr[W-1:2],2'b00}).
- bus_wdata  out  WORD_W  lane-steered store data.
- bus_ack  in  1  bus accepted / read data valid.
- bus_rdata  in  WORD_W  read data word.

Behaviour:
- Reset (async, rst_n low): state IDLE; bus_req, bus_we, done, err, stall = 0; bus_be = 0; bus_addr, bus_wdata, rdata = 0; timeout counter = 0. Reset mid-transaction abandons it; bus_req drops immediately.
- States: IDLE, BUSY, RESP.
- IDLE, op_ready = 1. On op_valid:
  - mem_op = NOP: done pulses next cycle (RESP), no bus activity, err = 0, rdata = 0.
  - Misaligned (half with addr[0] = 1; word with addr[1:0] != 0): go to RESP with err = 1, no bus_req.
  - Otherwise: latch op and addr[1:0], drive the bus registers, go to BUSY.
  - Unknown codes behave as NOP.
- Byte enables: byte = 4'b0001 << addr[1:0]; half = 4'b0011 << addr[1:0]; word = 4'b1111.
- Store data: byte replicated to all four lanes ({4{wdata[7:0]}}); half replicated ({2{wdata[15:0]}}); word unchanged. Loads drive bus_wdata = 0 and bus_we = 0.
- BUSY:
  - bus_req = 1; request fields held stable until ack.
  - stall = 1; it is combinational and also asserted in IDLE when op_valid carries a non-NOP op, so upstream freezes that same cycle.
  - The counter increments each BUSY cycle.
  - bus_ack seen: capture bus_rdata, go to RESP; bus_req drops the cycle after ack.
  - Counter reaches TIMEOUT without ack: drop bus_req, go to RESP with err = 1, rdata = 0.
  - Ack in the same cycle the counter hits TIMEOUT counts as success.
- Load extraction from the captured word, shifted right by 8*addr[1:0]:
  - RD_BYTE sign-extends bit 7; RD_BYTEU zero-extends.
  - RD_HALF sign-extends bit 15; RD_HALFU zero-extends.
  - RD_WORD passes the word through.
  - Stores return rdata = 0.
- RESP:
  - done = 1 for exactly one cycle, with rdata/err valid; stall = 0.
  - Return to IDLE next cycle.
  - Counter clears in RESP.
  - op_valid is ignored in RESP; op_ready = 0.
- Latency: NOP/misaligned = 1 cycle to done. Bus op = 1 + (cycles to ack) + 1.
- Back-to-back: a new request is accepted in the IDLE cycle after RESP. There is at most one outstanding transaction and no queueing.
- Signal timing: all outputs except stall and op_ready are registered.

Test Plan:
- SW addr=0x100 wdata=0xDEADBEEF, ack after 2 cycles -> bus_be=1111, bus_addr=0x100, bus_we=1, done 4 cycles after accept, err=0.
- SB addr=0x103 wdata=0x000000A5 -> bus_be=1000, bus_wdata=0xA5A5A5A5, bus_addr=0x100.
- LB addr=0x202 with bus_rdata=0x12F45678 -> rdata=0xFFFFFFF4; repeat with LBU -> 0x000000F4; LHU addr=0x202 -> 0x000012F4.
- LW addr=0x301 -> no bus_req, done+err next cycle, rdata=0; SH addr=0x101 -> same.
- LW with ack never asserted, TIMEOUT=16 -> bus_req high 16 cycles then low, done+err pulse, FSM returns to IDLE.
- Deassert rst_n while BUSY -> bus_req/stall 0 immediately; after release, a fresh SW completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage responder: one req/ack bus transaction per accepted op, with byte/half/word
// lane steering, alignment checks, ack timeout and sign/zero-extended load return.
module mem_access_unit #(
    parameter int WORD_W   = 32,
    parameter int MEM_OP_W = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                op_valid,
    output logic                op_ready,
    input  logic [MEM_OP_W-1:0] mem_op,
    input  logic [WORD_W-1:0]   addr,
    input  logic [WORD_W-1:0]   wdata,
    output logic                stall,
    output logic                done,
    output logic [WORD_W-1:0]   rdata,
    output logic                err,
    output logic                bus_req,
    output logic                bus_we,
    output logic [3:0]          bus_be,
    output logic [WORD_W-1:0]   bus_addr,
    output logic [WORD_W-1:0]   bus_wdata,
    input  logic                bus_ack,
    input  logic [WORD_W-1:0]   bus_rdata
);

    localparam logic [MEM_OP_W-1:0] MEM_OP_NOP      = MEM_OP_W'(0);
    localparam logic [MEM_OP_W-1:0] MEM_OP_WR_BYTE  = MEM_OP_W'(1);
    localparam logic [MEM_OP_W-1:0] MEM_OP_WR_HALF  = MEM_OP_W'(2);
    localparam logic [MEM_OP_W-1:0] MEM_OP_WR_WORD  = MEM_OP_W'(3);
    localparam logic [MEM_OP_W-1:0] MEM_OP_RD_BYTE  = MEM_OP_W'(4);
    localparam logic [MEM_OP_W-1:0] MEM_OP_RD_BYTEU = MEM_OP_W'(5);
    localparam logic [MEM_OP_W-1:0] MEM_OP_RD_HALF  = MEM_OP_W'(6);
    localparam logic [MEM_OP_W-1:0] MEM_OP_RD_HALFU = MEM_OP_W'(7);
    localparam logic [MEM_OP_W-1:0] MEM_OP_RD_WORD  = MEM_OP_W'(8);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t                state, state_nx;
    logic [7:0]            cnt, cnt_nx;
    logic [MEM_OP_W-1:0]   op_q, op_q_nx;
    logic [1:0]            off_q, off_q_nx;
    logic                  bus_req_nx, bus_we_nx, done_nx, err_nx;
    logic [3:0]            bus_be_nx;
    logic [WORD_W-1:0]     bus_addr_nx, bus_wdata_nx, rdata_nx;

    logic                  dec_known, dec_wr, dec_misalign;
    logic [1:0]            dec_size;
    logic [WORD_W-1:0]     lane_word, load_val;

    // dec_size: 0 = byte, 1 = half, 2 = word; NOP and unknown codes stay unknown
    always_comb begin
        dec_known = 1'b1;
        dec_wr    = 1'b0;
        dec_size  = 2'd0;
        case (mem_op)
            MEM_OP_WR_BYTE:                   begin dec_wr = 1'b1; dec_size = 2'd0; end
            MEM_OP_WR_HALF:                   begin dec_wr = 1'b1; dec_size = 2'd1; end
            MEM_OP_WR_WORD:                   begin dec_wr = 1'b1; dec_size = 2'd2; end
            MEM_OP_RD_BYTE, MEM_OP_RD_BYTEU:  dec_size = 2'd0;
            MEM_OP_RD_HALF, MEM_OP_RD_HALFU:  dec_size = 2'd1;
            MEM_OP_RD_WORD:                   dec_size = 2'd2;
            default:                          dec_known = 1'b0;
        endcase
        dec_misalign = ((dec_size == 2'd1) && addr[0]) ||
                       ((dec_size == 2'd2) && (addr[1:0] != 2'b00));
    end

    always_comb begin
        lane_word = bus_rdata >> {off_q, 3'b000};
        case (op_q)
            MEM_OP_RD_BYTE:  load_val = {{(WORD_W-8){lane_word[7]}}, lane_word[7:0]};
            MEM_OP_RD_BYTEU: load_val = {{(WORD_W-8){1'b0}}, lane_word[7:0]};
            MEM_OP_RD_HALF:  load_val = {{(WORD_W-16){lane_word[15]}}, lane_word[15:0]};
            MEM_OP_RD_HALFU: load_val = {{(WORD_W-16){1'b0}}, lane_word[15:0]};
            MEM_OP_RD_WORD:  load_val = lane_word;
            default:         load_val = '0;
        endcase
    end

    assign op_ready = (state == IDLE);
    assign stall    = (state == BUSY) || ((state == IDLE) && op_valid && dec_known);

    always_comb begin
        state_nx     = state;
        cnt_nx       = cnt;
        op_q_nx      = op_q;
        off_q_nx     = off_q;
        bus_req_nx   = bus_req;
        bus_we_nx    = bus_we;
        bus_be_nx    = bus_be;
        bus_addr_nx  = bus_addr;
        bus_wdata_nx = bus_wdata;
        done_nx      = 1'b0;
        err_nx       = 1'b0;
        rdata_nx     = rdata;
        case (state)
            IDLE: begin
                if (op_valid) begin
                    if (!dec_known || dec_misalign) begin
                        state_nx = RESP;
                        done_nx  = 1'b1;
                        err_nx   = dec_known;
                        rdata_nx = '0;
                    end else begin
                        state_nx    = BUSY;
                        cnt_nx      = 8'd0;
                        op_q_nx     = mem_op;
                        off_q_nx    = addr[1:0];
                        bus_req_nx  = 1'b1;
                        bus_we_nx   = dec_wr;
                        bus_addr_nx = {addr[WORD_W-1:2], 2'b00};
                        case (dec_size)
                            2'd0:    bus_be_nx = 4'b0001 << addr[1:0];
                            2'd1:    bus_be_nx = 4'b0011 << addr[1:0];
                            default: bus_be_nx = 4'b1111;
                        endcase
                        if (!dec_wr)
                            bus_wdata_nx = '0;
                        else if (dec_size == 2'd0)
                            bus_wdata_nx = {(WORD_W/8){wdata[7:0]}};
                        else if (dec_size == 2'd1)
                            bus_wdata_nx = {(WORD_W/16){wdata[15:0]}};
                        else
                            bus_wdata_nx = wdata;
                    end
                end
            end
            BUSY: begin
                cnt_nx = cnt + 8'd1;
                // an ack on the terminal cycle still wins over the timeout
                if (bus_ack || (cnt_nx == 8'(TIMEOUT))) begin
                    state_nx     = RESP;
                    done_nx      = 1'b1;
                    err_nx       = !bus_ack;
                    rdata_nx     = bus_ack ? load_val : '0;
                    bus_req_nx   = 1'b0;
                    bus_we_nx    = 1'b0;
                    bus_be_nx    = 4'b0000;
                    bus_addr_nx  = '0;
                    bus_wdata_nx = '0;
                end
            end
            RESP: begin
                cnt_nx   = 8'd0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            op_q      <= MEM_OP_NOP;
            off_q     <= 2'b00;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= 4'b0000;
            bus_addr  <= '0;
            bus_wdata <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            op_q      <= op_q_nx;
            off_q     <= off_q_nx;
            bus_req   <= bus_req_nx;
            bus_we    <= bus_we_nx;
            bus_be    <= bus_be_nx;
            bus_addr  <= bus_addr_nx;
            bus_wdata <= bus_wdata_nx;
            done      <= done_nx;
            err       <= err_nx;
            rdata     <= rdata_nx;
        end
    end

endmodule
